// File: rtl/pipe_exc_reg.sv
// rtl/pipe_exc_reg.sv - exception-carrying pipeline register with stall, bubble and CP0 flush
// Optional faulting-address tracking is enabled by defining EXC_BADVADDR_EN.
module pipe_exc_reg #(
  parameter int              CODE_W   = 5,
  parameter int              PC_W     = 32,
  parameter int              NSRC     = 2,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Stall,
  input  logic                   Bubble,
  input  logic                   ActivateCP0,
  input  logic                   CoolCP0,
  input  logic                   In_Valid,
  input  logic [CODE_W-1:0]      In_ExcCode,
  input  logic [PC_W-1:0]        In_PC,
  input  logic                   In_BD,
  input  logic [NSRC-1:0]        Src_Req,
  input  logic [NSRC*CODE_W-1:0] Src_Code,
`ifdef EXC_BADVADDR_EN
  input  logic [PC_W-1:0]        In_BadVAddr,
  input  logic [NSRC*PC_W-1:0]   Src_BadVAddr,
  output logic [PC_W-1:0]        Out_BadVAddr,
`endif
  output logic                   Out_Valid,
  output logic [CODE_W-1:0]      Out_ExcCode,
  output logic [PC_W-1:0]        Out_PC,
  output logic                   Out_BD,
  output logic                   Out_HasExc
);

  logic              flush;
  logic [CODE_W-1:0] src_code;
  logic [CODE_W-1:0] merged_code;
`ifdef EXC_BADVADDR_EN
  logic [PC_W-1:0]   src_addr;
  logic [PC_W-1:0]   merged_addr;
`endif

  assign flush = ActivateCP0 | CoolCP0;

  // Scan from the highest index down so the lowest-index live request wins;
  // a request carrying code 0 never displaces anything.
  always_comb begin
    src_code = '0;
`ifdef EXC_BADVADDR_EN
    src_addr = '0;
`endif
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (Src_Req[i] && (Src_Code[i*CODE_W +: CODE_W] != '0)) begin
        src_code = Src_Code[i*CODE_W +: CODE_W];
`ifdef EXC_BADVADDR_EN
        src_addr = Src_BadVAddr[i*PC_W +: PC_W];
`endif
      end
    end
  end

  always_comb begin
    merged_code = '0;
`ifdef EXC_BADVADDR_EN
    merged_addr = '0;
`endif
    if (In_Valid) begin
      if (In_ExcCode != '0) begin
        merged_code = In_ExcCode;
`ifdef EXC_BADVADDR_EN
        merged_addr = In_BadVAddr;
`endif
      end else begin
        merged_code = src_code;
`ifdef EXC_BADVADDR_EN
        merged_addr = src_addr;
`endif
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Out_Valid   <= 1'b0;
      Out_ExcCode <= '0;
      Out_PC      <= RESET_PC;
      Out_BD      <= 1'b0;
      Out_HasExc  <= 1'b0;
    end else if (flush) begin
      // PC still follows the input so an interrupt on a flushed slot has an EPC.
      Out_Valid   <= 1'b0;
      Out_ExcCode <= '0;
      Out_PC      <= In_PC;
      Out_BD      <= 1'b0;
      Out_HasExc  <= 1'b0;
    end else if (!Stall) begin
      if (Bubble) begin
        Out_Valid   <= 1'b0;
        Out_ExcCode <= '0;
        Out_HasExc  <= 1'b0;
      end else begin
        Out_Valid   <= In_Valid;
        Out_ExcCode <= merged_code;
        Out_HasExc  <= (merged_code != '0);
      end
      Out_PC <= In_PC;
      Out_BD <= In_BD;
    end
  end

`ifdef EXC_BADVADDR_EN
  always_ff @(posedge Clk) begin
    if (Rst || flush) begin
      Out_BadVAddr <= '0;
    end else if (!Stall) begin
      Out_BadVAddr <= Bubble ? '0 : merged_addr;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_exc_reg.sv
// tb/tb_pipe_exc_reg.sv - randomized self-checking bench for pipe_exc_reg
module tb_pipe_exc_reg;
  localparam int CODE_W = 5;
  localparam int PC_W   = 32;
  localparam int NSRC   = 2;

  logic                   Clk = 1'b0;
  logic                   Rst, Stall, Bubble, ActivateCP0, CoolCP0;
  logic                   In_Valid, In_BD;
  logic [CODE_W-1:0]      In_ExcCode;
  logic [PC_W-1:0]        In_PC;
  logic [NSRC-1:0]        Src_Req;
  logic [NSRC*CODE_W-1:0] Src_Code;
  logic                   Out_Valid, Out_BD, Out_HasExc;
  logic [CODE_W-1:0]      Out_ExcCode;
  logic [PC_W-1:0]        Out_PC;
`ifdef EXC_BADVADDR_EN
  logic [PC_W-1:0]        In_BadVAddr, Out_BadVAddr;
  logic [NSRC*PC_W-1:0]   Src_BadVAddr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the register after the most recent edge.
  logic              m_valid, m_bd;
  logic [CODE_W-1:0] m_code;
  logic [PC_W-1:0]   m_pc;
  logic [PC_W-1:0]   m_addr;

  pipe_exc_reg #(.CODE_W(CODE_W), .PC_W(PC_W), .NSRC(NSRC), .RESET_PC(32'h0000_3000)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Bubble(Bubble),
    .ActivateCP0(ActivateCP0), .CoolCP0(CoolCP0),
    .In_Valid(In_Valid), .In_ExcCode(In_ExcCode), .In_PC(In_PC), .In_BD(In_BD),
    .Src_Req(Src_Req), .Src_Code(Src_Code),
`ifdef EXC_BADVADDR_EN
    .In_BadVAddr(In_BadVAddr), .Src_BadVAddr(Src_BadVAddr), .Out_BadVAddr(Out_BadVAddr),
`endif
    .Out_Valid(Out_Valid), .Out_ExcCode(Out_ExcCode), .Out_PC(Out_PC),
    .Out_BD(Out_BD), .Out_HasExc(Out_HasExc)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Winner index of the merge, -1 = carried exception, -2 = none.
  function automatic int winner();
    if (!In_Valid) return -2;
    if (In_ExcCode != 0) return -1;
    for (int i = 0; i < NSRC; i++) begin
      logic [CODE_W-1:0] c;
      c = Src_Code[i*CODE_W +: CODE_W];
      if (Src_Req[i] && c != 0) return i;
    end
    return -2;
  endfunction

  task automatic model_edge();
    int w;
    logic [CODE_W-1:0] code;
    logic [PC_W-1:0]   addr;
    w = winner();
    code = 0;
    addr = 0;
    if (w == -1) begin
      code = In_ExcCode;
`ifdef EXC_BADVADDR_EN
      addr = In_BadVAddr;
`endif
    end else if (w >= 0) begin
      code = Src_Code[w*CODE_W +: CODE_W];
`ifdef EXC_BADVADDR_EN
      addr = Src_BadVAddr[w*PC_W +: PC_W];
`endif
    end
    if (Rst) begin
      m_valid = 0; m_code = 0; m_bd = 0; m_pc = 32'h3000; m_addr = 0;
    end else if (ActivateCP0 || CoolCP0) begin
      m_valid = 0; m_code = 0; m_bd = 0; m_pc = In_PC; m_addr = 0;
    end else if (Stall) begin
      // hold
    end else if (Bubble) begin
      m_valid = 0; m_code = 0; m_pc = In_PC; m_bd = In_BD; m_addr = 0;
    end else begin
      m_valid = In_Valid; m_code = code; m_pc = In_PC; m_bd = In_BD; m_addr = addr;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
    check("valid",  Out_Valid,   m_valid);
    check("code",   Out_ExcCode, m_code);
    check("pc",     Out_PC,      m_pc);
    check("bd",     Out_BD,      m_bd);
    check("hasexc", Out_HasExc,  (m_code != 0));
`ifdef EXC_BADVADDR_EN
    check("badvaddr", Out_BadVAddr, m_addr);
`endif
  endtask

  task automatic idle();
    Rst = 0; Stall = 0; Bubble = 0; ActivateCP0 = 0; CoolCP0 = 0;
    In_Valid = 0; In_ExcCode = 0; In_PC = 32'h3000; In_BD = 0;
    Src_Req = 0; Src_Code = 0;
`ifdef EXC_BADVADDR_EN
    In_BadVAddr = 0; Src_BadVAddr = 0;
`endif
  endtask

  initial begin
    m_valid = 0; m_code = 0; m_pc = 0; m_bd = 0; m_addr = 0;
    idle();
    Rst = 1;
    step(); step();
    Rst = 0;
    step();
    check("reset_pc", Out_PC, 32'h3000);

    // Local merge: source 0 (code 10) beats source 1 (code 12)
    In_Valid = 1; In_PC = 32'h3004; Src_Req = 2'b11; Src_Code = {5'd12, 5'd10};
    step();
    check("merge_src0", Out_ExcCode, 10);
    In_ExcCode = 4;
    step();
    check("merge_carried", Out_ExcCode, 4);

    // Zero-code request is absent
    In_ExcCode = 0; Src_Req = 2'b01; Src_Code = {5'd12, 5'd0};
    step();
    check("zero_req", Out_ExcCode, 0);

    // Stall holds, then flush overrides stall
    Src_Req = 2'b01; Src_Code = {5'd0, 5'd10}; In_PC = 32'h3008;
    step();
    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      In_PC = $urandom; Src_Code = $urandom; Src_Req = $urandom; In_ExcCode = $urandom;
      step();
      check("stall_pc", Out_PC, 32'h3008);
      check("stall_code", Out_ExcCode, 10);
    end
    ActivateCP0 = 1; In_PC = 32'h300C;
    step();
    check("flush_pc", Out_PC, 32'h300C);
    check("flush_valid", Out_Valid, 0);

    // Bubble keeps PC/BD
    idle();
    In_Valid = 1; In_PC = 32'h3010; In_BD = 1; In_ExcCode = 8; Bubble = 1;
    step();
    check("bubble_bd", Out_BD, 1);
    check("bubble_code", Out_ExcCode, 0);

`ifdef EXC_BADVADDR_EN
    idle();
    In_Valid = 1; Src_Req = 2'b10; Src_Code = {5'd5, 5'd0};
    Src_BadVAddr = {32'h7F01, 32'h1234};
    step();
    check("bva_src1", Out_BadVAddr, 32'h7F01);
    CoolCP0 = 1;
    step();
    check("bva_flush", Out_BadVAddr, 0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      Rst         = ($urandom_range(0, 49) == 0);
      ActivateCP0 = ($urandom_range(0, 19) == 0);
      CoolCP0     = ($urandom_range(0, 19) == 0);
      Stall       = ($urandom_range(0, 4) == 0);
      Bubble      = ($urandom_range(0, 7) == 0);
      In_Valid    = ($urandom_range(0, 3) != 0);
      In_ExcCode  = ($urandom_range(0, 2) == 0) ? CODE_W'($urandom) : '0;
      In_PC       = $urandom;
      In_BD       = $urandom_range(0, 1) == 1;
      Src_Req     = NSRC'($urandom);
      for (int i = 0; i < NSRC; i++)
        Src_Code[i*CODE_W +: CODE_W] = ($urandom_range(0, 2) == 0) ? '0 : CODE_W'($urandom);
`ifdef EXC_BADVADDR_EN
      In_BadVAddr = $urandom;
      for (int i = 0; i < NSRC; i++) Src_BadVAddr[i*PC_W +: PC_W] = $urandom;
`endif
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
